sonic_gearbox_read_ctrl: RTL and testbench

Read-side controller for the 64->40 downstream gearbox. It owns the read pointer of the 64-bit circular word buffer (1-cycle-latency RAM) that feeds the gearbox. It gates the gearbox `ena` through start, prefill, run and stop, and turns gearbox `rdreq` pulses into RAM reads. It detects buffer underflow and overflow and keeps recovery statistics for the host.

---
 rtl/sonic_gearbox_read_ctrl.sv | 121 ++++++++++++
 tb/tb_sonic_gearbox_read_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sonic_gearbox_read_ctrl.sv
// Read-side controller for the 64->40 gearbox: owns the circular buffer read pointer,
// gates the gearbox enable through IDLE/PREFILL/RUN and tracks underflow/overflow.
module sonic_gearbox_read_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int PREFILL    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic                  rdreq,
  output logic [ADDR_WIDTH-1:0] ram_rdaddr,
  output logic                  ram_rden,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  gb_ena,
  output logic                  busy,
  output logic                  underflow,
  output logic                  overflow,
  output logic [31:0]           words_read,
  output logic [15:0]           underflow_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PREFILL = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] LP_PREFILL = (ADDR_WIDTH+1)'(PREFILL);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_underflow;
  logic                  r_overflow;
  logic [31:0]           r_words_read;
  logic [15:0]           r_uf_count;
  logic [ADDR_WIDTH:0]   w_level;
  logic                  w_empty;
  logic                  w_rden;
  logic                  w_uf_evt;
  logic                  w_ovf_evt;
  logic                  w_start_go;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Level wraps modulo 2^(ADDR_WIDTH+1); the extra MSB makes "full" distinct from "empty".
  assign w_level    = wr_ptr - r_rd_ptr;
  assign w_empty    = (w_level == '0);
  assign w_rden     = (r_state == S_RUN) & rdreq & ~w_empty;
  assign w_uf_evt   = (r_state == S_RUN) & rdreq & w_empty;
  assign w_ovf_evt  = w_level[ADDR_WIDTH] & (|w_level[ADDR_WIDTH-1:0]);
  assign w_start_go = (r_state == S_IDLE) & start & ~stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_go) w_next = S_PREFILL;
      end
      S_PREFILL: begin
        if (stop)                          w_next = S_IDLE;
        else if (w_level >= LP_PREFILL)    w_next = S_RUN;
      end
      S_RUN: begin
        if (stop)          w_next = S_IDLE;
        else if (w_uf_evt) w_next = S_PREFILL;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    gb_ena = (r_state == S_RUN);
    busy   = (r_state != S_IDLE);
  end

  // A start edge clears the sticky flags, but an overflow seen on that same edge still latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr     <= '0;
      r_words_read <= '0;
      r_underflow  <= 1'b0;
      r_overflow   <= 1'b0;
      r_uf_count   <= '0;
    end else begin
      if (w_rden) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_words_read <= r_words_read + 32'd1;
      end
      r_overflow <= (w_start_go ? 1'b0 : r_overflow) | w_ovf_evt;
      if (w_start_go) begin
        r_underflow <= 1'b0;
        r_uf_count  <= '0;
      end else if (w_uf_evt) begin
        r_underflow <= 1'b1;
        r_uf_count  <= sat_inc16(r_uf_count);
      end
    end
  end

  assign ram_rden        = w_rden;
  assign ram_rdaddr      = r_rd_ptr[ADDR_WIDTH-1:0];
  assign rd_ptr          = r_rd_ptr;
  assign underflow       = r_underflow;
  assign overflow        = r_overflow;
  assign words_read      = r_words_read;
  assign underflow_count = r_uf_count;

endmodule

// File: tb/tb_sonic_gearbox_read_ctrl.sv
// Bench for sonic_gearbox_read_ctrl: directed scenarios plus random traffic, checked
// every cycle against a behavioural model of the buffer level and session rules.
module tb_sonic_gearbox_read_ctrl;
  localparam int AW    = 4;
  localparam int PF    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 1 << (AW + 1);

  logic          clk = 1'b0;
  logic          reset, start, stop, rdreq;
  logic [AW:0]   wr_ptr;
  logic [AW-1:0] ram_rdaddr;
  logic          ram_rden;
  logic [AW:0]   rd_ptr;
  logic          gb_ena, busy, underflow, overflow;
  logic [31:0]   words_read;
  logic [15:0]   underflow_count;

  sonic_gearbox_read_ctrl #(.ADDR_WIDTH(AW), .PREFILL(PF)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .wr_ptr(wr_ptr), .rdreq(rdreq),
    .ram_rdaddr(ram_rdaddr), .ram_rden(ram_rden), .rd_ptr(rd_ptr), .gb_ena(gb_ena),
    .busy(busy), .underflow(underflow), .overflow(overflow), .words_read(words_read),
    .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model: session phase (0 idle, 1 prefill, 2 run), plain integer pointers and counters.
  int      m_phase;
  int      m_rd;
  longint  m_words;
  bit      m_uf, m_ovf;
  int      m_ufc;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int m_level();
    return (int'(wr_ptr) - m_rd + PMOD) % PMOD;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_rd = 0; m_words = 0; m_uf = 0; m_ovf = 0; m_ufc = 0;
  endtask

  task automatic check_all();
    int lvl;
    bit exp_rden;
    lvl      = m_level();
    exp_rden = (m_phase == 2) && rdreq && (lvl != 0);
    check_eq("gb_ena",   gb_ena, m_phase == 2);
    check_eq("busy",     busy, m_phase != 0);
    check_eq("ram_rden", ram_rden, exp_rden);
    check_eq("rd_ptr",   rd_ptr, m_rd);
    check_eq("rdaddr",   ram_rdaddr, m_rd % DEPTH);
    check_eq("underflow", underflow, m_uf);
    check_eq("overflow", overflow, m_ovf);
    check_eq("words_read", words_read, m_words[31:0]);
    check_eq("uf_count", underflow_count, m_ufc);
  endtask

  task automatic model_step();
    int lvl;
    bit rd, uf;
    lvl = m_level();
    rd  = (m_phase == 2) && rdreq && (lvl != 0);
    uf  = (m_phase == 2) && rdreq && (lvl == 0);
    if (rd) begin
      m_rd    = (m_rd + 1) % PMOD;
      m_words = (m_words + 1) % (64'd1 << 32);
    end
    if (uf) begin
      m_uf  = 1;
      m_ufc = (m_ufc < 65535) ? m_ufc + 1 : 65535;
    end
    if (m_phase == 0) begin
      if (start && !stop) begin
        m_phase = 1; m_uf = 0; m_ufc = 0; m_ovf = 0;
      end
    end else if (stop) begin
      m_phase = 0;
    end else if (m_phase == 1 && lvl >= PF) begin
      m_phase = 2;
    end else if (m_phase == 2 && uf) begin
      m_phase = 1;
    end
    if (lvl > DEPTH) m_ovf = 1;
  endtask

  // One clock: check at the falling edge, advance the model, then return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  logic [AW:0] saved_rd;
  logic [31:0] saved_words;
  int          addr_idx;
  int          guard;

  initial begin
    reset = 1'b1; start = 0; stop = 0; rdreq = 0; wr_ptr = '0;
    model_reset();
    #2;
    check_all();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Prefill: three words are not enough, the fourth releases RUN.
    wr_ptr = 3; rdreq = 1;
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("prefill_hold", gb_ena, 0);
    wr_ptr = 4; cycle();
    check_eq("prefill_release", gb_ena, 1);

    // Steady stream: 5 words per 8 cycles in and out, 800 cycles.
    addr_idx = 0;
    for (int c = 0; c < 800; c++) begin
      rdreq = ((c % 8) < 5);
      @(negedge clk);
      if (ram_rden && addr_idx < 40) begin
        check_eq("wrap_addr_seq", ram_rdaddr, addr_idx % 16);
        addr_idx++;
      end
      check_all();
      model_step();
      @(posedge clk);
      #1;
      if ((c % 8) < 5) wr_ptr = wr_ptr + 1'b1;
    end
    rdreq = 0;
    check_eq("steady_words", words_read, 500);
    check_eq("steady_rdptr", rd_ptr, 500 % PMOD);
    check_eq("steady_no_uf", underflow, 0);

    // Underflow: producer stalls, reader drains then hits empty.
    rdreq = 1;
    guard = 0;
    while (!m_uf && guard < 20) begin cycle(); guard++; end
    check_eq("uf_bound", guard < 20, 1);
    check_eq("uf_flag", underflow, 1);
    check_eq("uf_count1", underflow_count, 1);
    check_eq("uf_to_prefill", {busy, gb_ena}, 2'b10);
    wr_ptr = wr_ptr + 5'd4; cycle();
    check_eq("uf_resume", gb_ena, 1);

    // Stop and start together in RUN: stop wins.
    rdreq = 0;
    start = 1; stop = 1; saved_rd = rd_ptr; cycle();
    start = 0; stop = 0;
    check_eq("stop_idle", {busy, gb_ena}, 2'b00);
    rdreq = 1; cycle(); cycle();
    check_eq("stop_rd_held", rd_ptr, saved_rd);
    saved_words = words_read;
    start = 1; cycle(); start = 0;
    check_eq("restart_uf_clr", underflow, 0);
    check_eq("restart_ufc_clr", underflow_count, 0);
    check_eq("restart_words_kept", words_read, saved_words);

    // Random traffic with occasional stop/start.
    for (int c = 0; c < 2000; c++) begin
      rdreq = ($urandom_range(0, 9) < 7);
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 49) == 0);
      cycle();
      if (m_level() < DEPTH && $urandom_range(0, 9) < 6) wr_ptr = wr_ptr + 1'b1;
    end
    start = 0; rdreq = 0;
    stop = 1; cycle(); stop = 0;

    // Overflow: level 17 with a 16-word buffer.
    wr_ptr = rd_ptr + 5'd17; cycle();
    check_eq("ovf_set", overflow, 1);
    start = 1; cycle(); start = 0;
    cycle();
    check_eq("ovf_run", gb_ena, 1);
    rdreq = 1;
    @(negedge clk); check_all(); model_step();
    @(posedge clk);
    #1;
    reset = 1'b1; wr_ptr = '0;
    model_reset();
    #1;
    check_all();
    check_eq("async_rst_rdaddr", ram_rdaddr, 0);
    @(posedge clk); #1 reset = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
